// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - instruction sequencer for the multicycle SimpleRISC core
//
// Optional build macro: ILLEGAL_TRAP_EN
//   defined   : opcodes 21-31 set the sticky illegal flag and park the FSM in HALT
//   undefined : opcodes 21-31 retire as nop, illegal stays 0, HALT is unreachable
//
// Parameters:
//   CNT_W        width of the retired-instruction counter
//   RESET_PC_SEL pc_sel value driven while in reset or HALT
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   instruction        IR contents (opcode [31:27], I-bit [26]), valid from DECODE
//   imem_ack/dmem_ack  memory handshake completions, sampled on the clock edge
//   alu_done           iterative div/mod result ready
//   flag_eq/flag_gt    stored comparison flags, consumed in WB by beq/bgt
//   imem_req, ir_we    fetch request and IR load strobe
//   dmem_req, dmem_we  data access request and store qualifier
//   pc_we, pc_sel      PC update strobe and source (0 pc+4, 1 target, 2 ra)
//   rf_we, rf_wsel     register write strobe and source (0 ALU, 1 mem, 2 pc+4)
//   flags_we           comparison flag update
//   alu_op, alu_start  ALU function and div/mod start pulse
//   is_imm, is_call    decoded I-bit and call indicator for the target generator
//   illegal, halted    sticky illegal-opcode flag, HALT indicator
//   retired            retired-instruction count (wraps)
module multicycle_control_fsm #(
    parameter int         CNT_W        = 32,
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instruction,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             alu_done,
    input  logic             flag_eq,
    input  logic             flag_gt,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       rf_wsel,
    output logic             flags_we,
    output logic [3:0]       alu_op,
    output logic             alu_start,
    output logic             is_imm,
    output logic             is_call,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DIVWAIT,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state, state_nxt;
    logic [4:0]       opcode;
    logic             op_alu, op_divmod, op_cmp, op_ld, op_st, op_call;
    logic             trap;
    logic [CNT_W-1:0] retired_q;
    logic             unused_ok;

    assign opcode    = instruction[31:27];
    assign op_alu    = (opcode <= 5'd12);
    assign op_divmod = (opcode == 5'd3) || (opcode == 5'd4);
    assign op_cmp    = (opcode == 5'd5);
    assign op_ld     = (opcode == 5'd14);
    assign op_st     = (opcode == 5'd15);
    assign op_call   = (opcode == 5'd19);
    // Immediate/offset fields are consumed by the datapath, not here.
    assign unused_ok = &{1'b0, instruction[25:0]};

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    assign trap    = (opcode >= 5'd21);
    assign illegal = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state == S_DECODE && trap) begin
            illegal_q <= 1'b1;
        end
    end
`else
    assign trap    = 1'b0;
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WB) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign retired = retired_q;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        rf_we     = 1'b0;
        rf_wsel   = 2'd0;
        flags_we  = 1'b0;
        alu_op    = 4'd0;
        alu_start = 1'b0;
        is_imm    = 1'b0;
        is_call   = 1'b0;
        halted    = 1'b0;
        // Outputs are gated by rst_n so an asserted reset drops the
        // handshakes at once, before the state register is even observed.
        if (!rst_n) begin
            pc_sel = RESET_PC_SEL;
        end else begin
            if (state != S_FETCH && state != S_HALT) begin
                is_imm  = instruction[26];
                is_call = op_call;
                alu_op  = op_alu ? opcode[3:0] : 4'd0;
            end
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we     = 1'b1;
                        state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (trap) begin
                        state_nxt = S_HALT;
                    end else if (op_alu || op_ld || op_st) begin
                        state_nxt = S_EXEC;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
                S_EXEC: begin
                    flags_we = op_cmp;
                    if (op_ld || op_st) begin
                        state_nxt = S_MEM;
                    end else if (op_divmod) begin
                        alu_start = 1'b1;
                        state_nxt = S_DIVWAIT;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
                S_DIVWAIT: begin
                    if (alu_done) begin
                        state_nxt = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = op_st;
                    if (dmem_ack) begin
                        state_nxt = S_WB;
                    end
                end
                S_WB: begin
                    pc_we   = 1'b1;
                    rf_we   = (op_alu && !op_cmp) || op_ld || op_call;
                    rf_wsel = op_ld ? 2'd1 : (op_call ? 2'd2 : 2'd0);
                    case (opcode)
                        5'd16:        pc_sel = flag_eq ? 2'd1 : 2'd0;
                        5'd17:        pc_sel = flag_gt ? 2'd1 : 2'd0;
                        5'd18, 5'd19: pc_sel = 2'd1;
                        5'd20:        pc_sel = 2'd2;
                        default:      pc_sel = 2'd0;
                    endcase
                    state_nxt = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                    pc_sel = RESET_PC_SEL;
                end
                default: begin
                    state_nxt = S_FETCH;
                end
            endcase
        end
    end

endmodule
